// File: rtl/exhaustive_sweep_checker.sv
`timescale 1ns/1ps
// exhaustive_sweep_checker
// Steps an N_IN-bit input vector through every value 0 .. 2^N_IN-1 and feeds it
// to two implementations of the same combinational function. Each vector is
// held for SETTLE cycles, then the two outputs are compared for one cycle.
// Mismatches are counted (saturating), and the first failing vector is captured.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a sweep (honoured only when idle or done)
//   vec_out      vector currently applied (bit0 changes fastest)
//   f_ref        output of the reference implementation
//   f_dut        output of the implementation under check
//   busy         sweep in progress
//   done         sweep finished; held until the next start
//   pass         done with zero mismatches
//   mismatch_cnt saturating count of mismatching vectors
//   fail_valid   at least one mismatch captured in this sweep
//   fail_vec     first mismatching vector (valid with fail_valid)
module exhaustive_sweep_checker #(
  parameter int N_IN         = 4,
  parameter int SETTLE       = 2,
  parameter int STOP_ON_FAIL = 0,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic             f_ref,
  input  logic             f_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic          mismatch;

  // Four-state compare so an X or Z from either implementation counts as a
  // failure in simulation; in hardware this reduces to a plain inequality.
  assign mismatch = (f_ref !== f_dut);

  // Sweep sequencer. HOLD counts settle_cnt down to 1 so the vector is held for
  // exactly SETTLE cycles; CHECK adds one more, giving SETTLE+1 cycles per vector.
  // pass is registered on entry to DONE: because the counter saturates rather
  // than wraps, "no mismatch ever seen" is equivalent to mismatch_cnt == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      fail_valid   <= 1'b0;
      fail_vec     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= HOLD;
            vec_out      <= '0;
            settle_cnt   <= SW'(SETTLE);
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            fail_vec     <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
          end
        end

        HOLD: begin
          if (settle_cnt == SW'(1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end

        CHECK: begin
          if (mismatch) begin
            if (mismatch_cnt != '1) begin
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            if (!fail_valid) begin
              fail_vec   <= vec_out;
              fail_valid <= 1'b1;
            end
          end
          if ((mismatch && (STOP_ON_FAIL != 0)) || (vec_out == LAST_VEC)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(mismatch || fail_valid);
          end else begin
            state      <= HOLD;
            vec_out    <= vec_out + N_IN'(1);
            settle_cnt <= SW'(SETTLE);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exhaustive_sweep_checker.md
Name: exhaustive_sweep_checker

Overview:
- Sequential stimulus-and-check stage for small combinational blocks.
- Drives every input vector of an N_IN-input function to two implementations, typically structural and behavioural, e.g. a 4-input A/B/C/D function.
- Waits a settle interval, compares the two outputs and accumulates pass/fail results.
- Replaces free-running toggle benches with a synthesizable, cycle-exact sweep that also fits an FPGA self-test wrapper.

Parameters:
- N_IN, 4, number of function inputs; sweep covers 0 .. 2^N_IN-1.
- SETTLE, 2, cycles each vector is held before comparison (>=1).
- STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = sweep all vectors.
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; sampled in IDLE or DONE only.
- vec_out  output  N_IN  applied vector; bit0 = A (fastest-changing), bit N_IN-1 = slowest.
- f_ref  input  1  output of the reference implementation.
- f_dut  input  1  output of the implementation under check.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE until the next start.
- pass  output  1  done && mismatch_cnt==0.
- mismatch_cnt  output  CNT_W  mismatches seen; saturates at all-ones.
- fail_valid  output  1  at least one mismatch captured this sweep.
- fail_vec  output  N_IN  first mismatching vector; valid when fail_valid=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any state):
  - state=IDLE; vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0, fail_vec=0.
  - Takes effect immediately, including mid-sweep; no partial results retained.
- FSM states: IDLE, HOLD, CHECK, DONE.
- IDLE:
  - start=1 -> next edge: vec_out=0, settle counter=SETTLE, mismatch_cnt=0, fail_valid=0, fail_vec=0, busy=1; go to HOLD.
- HOLD:
  - Stays exactly SETTLE cycles with vec_out stable, then goes to CHECK.
- CHECK (1 cycle): sample f_ref/f_dut.
  - Mismatch: f_ref != f_dut, or either input is X/Z in simulation (4-state compare, !== semantics).
  - On mismatch: mismatch_cnt+1, saturating (no wrap). If fail_valid=0, fail_vec=vec_out and fail_valid=1; later mismatches never overwrite fail_vec.
  - Mismatch and STOP_ON_FAIL=1 -> DONE; vec_out holds the failing vector.
  - Else vec_out == 2^N_IN-1 -> DONE; vec_out holds the final vector and does not wrap.
  - Else vec_out+1, settle counter reloaded, go to HOLD.
- DONE:
  - busy=0, done=1; pass and results stable.
  - start=1 -> same action as start in IDLE (full clear, restart at vector 0).
- start while busy=1 is ignored; no restart, no effect on counters.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - Full sweep: done rises 2^N_IN*(SETTLE+1) cycles after the edge that accepted start. Defaults: 16*3 = 48 cycles.
  - Stop-on-fail at vector k: done rises (k+1)*(SETTLE+1) cycles after acceptance.
- All outputs registered; no combinational path from f_ref/f_dut to outputs.

Test Plan:
- Defaults, f_ref and f_dut driven by identical functions of vec_out, pulse start -> vec_out steps 0..15, 3 cycles each; done=1 at cycle 48; pass=1, mismatch_cnt=0, fail_valid=0, vec_out=15.
- STOP_ON_FAIL=0, f_dut inverted only at vector 5 and vector 12 -> done at cycle 48; mismatch_cnt=2, fail_vec=5, fail_valid=1, pass=0.
- STOP_ON_FAIL=1, mismatch injected at vector 5 -> done at cycle 18; vec_out=5, mismatch_cnt=1, fail_vec=5; vectors 6..15 never applied.
- Corner cases:
  - f_dut=X at vector 3 -> counted as a mismatch, fail_vec=3.
  - CNT_W=3 with f_dut=~f_ref for all vectors -> mismatch_cnt=7 (saturated), fail_vec=0.
- Reset and start control:
  - Assert rst_n=0 asynchronously while vec_out=9 -> all outputs return to reset values before the next edge; state IDLE.
  - start pulsed during the sweep -> ignored, done still at cycle 48.
  - start in DONE -> counters cleared and sweep restarts at vector 0.
